br_pht_gshare: RTL and testbench

//  Pattern history table (PHT) with gshare indexing for the branch predictor.

---
 rtl/br_pht_gshare_if.sv | 24 ++
 rtl/br_pht_gshare.sv | 52 +++++
 tb/tb_br_pht_gshare.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/br_pht_gshare_if.sv
// br_pht_gshare_if: lookup, update and fin_sta_mac signals of the gshare PHT.
interface br_pht_gshare_if #(parameter int ADDR_W = 6);
   logic              lk_valid;
   logic [ADDR_W-1:0] lk_pc;
   logic              pred_valid;
   logic              pred_taken;
   logic [ADDR_W-1:0] pred_idx;
   logic              upd_valid;
   logic              upd_ready;
   logic [ADDR_W-1:0] upd_idx;
   logic              upd_taken;
   logic [1:0]        fsm_cnt;
   logic              fsm_torn;
   logic [1:0]        fsm_next;
   logic              fsm_wr_en;
   modport slave(
      input  lk_valid, lk_pc, upd_valid, upd_idx, upd_taken, fsm_next, fsm_wr_en,
      output pred_valid, pred_taken, pred_idx, upd_ready, fsm_cnt, fsm_torn
   );
   modport master(
      output lk_valid, lk_pc, upd_valid, upd_idx, upd_taken, fsm_next, fsm_wr_en,
      input  pred_valid, pred_taken, pred_idx, upd_ready, fsm_cnt, fsm_torn
   );
endinterface

// File: rtl/br_pht_gshare.sv
// br_pht_gshare: gshare-indexed table of 2-bit counters, updated through fin_sta_mac.
module br_pht_gshare #(
   parameter int         ADDR_W   = 6,
   parameter int         GHR_W    = 6,
   parameter logic [1:0] CNT_INIT = 2'b01
) (
   input logic            clk,
   input logic            reset,
   br_pht_gshare_if.slave b
);
   typedef enum logic [1:0] {IDLE, RD, WB} state_t;
   state_t            state, state_nx;
   logic [1:0]        pht [1<<ADDR_W];
   logic [GHR_W-1:0]  ghr;
   logic [ADDR_W-1:0] idx_r, lk_idx;
   logic              taken_r, accept, wr, lk_hi;
   assign lk_idx = b.lk_pc ^ ADDR_W'(ghr);
   assign accept = b.upd_valid && state == IDLE;
   assign wr = state == WB && b.fsm_wr_en;
   // write-first bypass: a lookup colliding with the WB write sees the new counter
   assign lk_hi = (wr && lk_idx == idx_r) ? b.fsm_next[1] : pht[lk_idx][1];
   assign b.upd_ready = state == IDLE;
   assign b.fsm_cnt = pht[idx_r];
   assign b.fsm_torn = taken_r;
   always_comb state_nx = state == IDLE ? (b.upd_valid ? RD : IDLE) : (state == RD ? WB : IDLE);
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk or posedge reset)
      if (reset) for (int i = 0; i < (1<<ADDR_W); i++) pht[i] <= CNT_INIT;
      else if (wr) pht[idx_r] <= b.fsm_next;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         ghr          <= '0;
         idx_r        <= '0;
         taken_r      <= 1'b0;
         b.pred_valid <= 1'b0;
         b.pred_taken <= 1'b0;
         b.pred_idx   <= '0;
      end else begin
         b.pred_valid <= b.lk_valid;
         if (b.lk_valid) begin
            b.pred_idx   <= lk_idx;
            b.pred_taken <= lk_hi;
         end
         if (accept) begin
            idx_r   <= b.upd_idx;
            taken_r <= b.upd_taken;
            ghr     <= GHR_W'({ghr, b.upd_taken});
         end
      end
endmodule

// File: tb/tb_br_pht_gshare.sv
// tb_br_pht_gshare: random and directed checks of the gshare PHT against a table model.
module tb_br_pht_gshare;
   logic clk, reset;
   int   n_chk, n_fail;
   int   cnt_m [64];
   int   ghr_m, ph, pidx, exp_pidx;
   bit   ptk, exp_pv, exp_pt;
   logic [1:0] fcnt;
   logic       ftorn;
   br_pht_gshare_if #(.ADDR_W(6)) b();
   br_pht_gshare #(.ADDR_W(6), .GHR_W(6), .CNT_INIT(2'b01)) dut(.clk(clk), .reset(reset), .b(b.slave));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   // stand-in for fin_sta_mac: registers counter/outcome, saturating next state
   always_ff @(posedge clk) begin
      fcnt  <= b.fsm_cnt;
      ftorn <= b.fsm_torn;
   end
   assign b.fsm_next  = ftorn ? (fcnt == 2'd3 ? 2'd3 : 2'(fcnt + 2'd1)) : (fcnt == 2'd0 ? 2'd0 : 2'(fcnt - 2'd1));
   assign b.fsm_wr_en = ftorn ? fcnt != 2'd3 : fcnt != 2'd0;

   function automatic int sat(int c, bit t);
      return t ? (c == 3 ? 3 : c + 1) : (c == 0 ? 0 : c - 1);
   endfunction

   task automatic model_init;
      foreach (cnt_m[i]) cnt_m[i] = 1;
      ghr_m = 0; ph = 0; pidx = 0; ptk = 0;
      exp_pv = 0; exp_pt = 0; exp_pidx = 0;
   endtask

   // one clock cycle of stimulus; expectations derived from the counter table model
   task automatic cyc(bit lv, int pc, bit uv, int ui, bit ut);
      int idx, v;
      b.lk_valid = lv; b.lk_pc = 6'(pc); b.upd_valid = uv; b.upd_idx = 6'(ui); b.upd_taken = ut;
      #1;
      n_chk++;
      if (b.upd_ready !== (ph == 0)) begin
         n_fail++; $display("FAIL upd_ready: got %b want %b", b.upd_ready, ph == 0);
      end
      if (ph != 0) begin
         n_chk++;
         if (b.fsm_cnt !== 2'(cnt_m[pidx]) || b.fsm_torn !== ptk) begin
            n_fail++; $display("FAIL fsm_out: got cnt=%0d torn=%b want cnt=%0d torn=%b", b.fsm_cnt, b.fsm_torn, cnt_m[pidx], ptk);
         end
      end
      if (ph == 2) begin
         n_chk++;
         if (b.fsm_wr_en !== (sat(cnt_m[pidx], ptk) != cnt_m[pidx])) begin
            n_fail++; $display("FAIL fsm_wr_en: got %b want %b", b.fsm_wr_en, sat(cnt_m[pidx], ptk) != cnt_m[pidx]);
         end
      end
      idx = (pc ^ ghr_m) & 63;
      v = (ph == 2 && pidx == idx) ? sat(cnt_m[idx], ptk) : cnt_m[idx];
      @(posedge clk);
      exp_pv = lv;
      if (lv) begin exp_pidx = idx; exp_pt = v >= 2; end
      if (ph == 2) begin cnt_m[pidx] = sat(cnt_m[pidx], ptk); ph = 0; end
      else if (ph == 1) ph = 2;
      else if (uv) begin pidx = ui & 63; ptk = ut; ghr_m = ((ghr_m << 1) | int'(ut)) & 63; ph = 1; end
      #1;
      n_chk++;
      if (b.pred_valid !== exp_pv || b.pred_taken !== exp_pt || b.pred_idx !== 6'(exp_pidx)) begin
         n_fail++;
         $display("FAIL pred: got v=%b t=%b idx=%0d want v=%b t=%b idx=%0d", b.pred_valid, b.pred_taken, b.pred_idx, exp_pv, exp_pt, exp_pidx);
      end
   endtask

   task automatic upd(int ui, bit ut);
      cyc(0, 0, 1, ui, ut);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
   endtask

   task automatic test_reset;
      b.lk_valid = 0; b.lk_pc = 0; b.upd_valid = 0; b.upd_idx = 0; b.upd_taken = 0;
      reset = 1'b1;
      #2;
      n_chk++;
      if (b.upd_ready !== 1'b1 || b.fsm_torn !== 1'b0 || b.pred_valid !== 1'b0 || b.fsm_cnt !== 2'b01) begin
         n_fail++;
         $display("FAIL reset_held: got rdy=%b torn=%b pv=%b cnt=%0d want 1 0 0 1", b.upd_ready, b.fsm_torn, b.pred_valid, b.fsm_cnt);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      model_init();
   endtask

   task automatic test_lookup_init;
      cyc(1, 5, 0, 0, 0);
      for (int i = 0; i < 64; i++) cyc(1, i, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
   endtask

   task automatic test_saturate;
      upd(3, 1);
      upd(3, 1);
      cyc(1, 3 ^ ghr_m, 0, 0, 0);
      upd(3, 1);
      upd(3, 1);
      cyc(1, 3 ^ ghr_m, 0, 0, 0);
   endtask

   task automatic test_bypass;
      cyc(0, 0, 1, 3, 0);
      cyc(1, 3 ^ ghr_m, 0, 0, 0);
      cyc(1, 3 ^ ghr_m, 0, 0, 0);
      cyc(0, 0, 1, 3, 0);
      cyc(1, 3 ^ ghr_m, 0, 0, 0);
      cyc(1, 3 ^ ghr_m, 0, 0, 0);
      cyc(1, 3 ^ ghr_m, 0, 0, 0);
   endtask

   task automatic test_ghr;
      test_reset();
      upd(9, 1);
      upd(9, 1);
      upd(9, 0);
      cyc(1, 6, 0, 0, 0);
      n_chk++;
      if (b.pred_idx !== 6'd0) begin
         n_fail++; $display("FAIL ghr_idx: got %0d want 0", b.pred_idx);
      end
      cyc(1, 6, 1, 2, 1);
      cyc(1, 6, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
   endtask

   task automatic test_reset_in_wb;
      upd(7, 1);
      cyc(0, 0, 1, 7, 1);
      cyc(0, 0, 0, 0, 0);
      test_reset();
      for (int i = 0; i < 64; i++) cyc(1, i, 0, 0, 0);
      upd(7, 0);
   endtask

   task automatic test_random;
      for (int i = 0; i < 600; i++) begin
         int pc;
         pc = ($urandom_range(0, 2) == 0) ? (($urandom_range(0, 3)) ^ ghr_m) & 63 : int'($urandom_range(0, 63));
         cyc(1'($urandom), pc, 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
      end
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      test_reset();
      test_lookup_init();
      test_saturate();
      test_bypass();
      test_ghr();
      test_reset_in_wb();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
